// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen -- SPI serial clock generator.
//
// Produces a CPOL-idle serial clock with a half-period of CLK_DIV clk cycles,
// DATA_WIDTH sclk cycles per transfer, and single-cycle strobes marking each
// leading (away from CPOL) and trailing (back to CPOL) sclk transition.
//
// Parameters
//   CLK_DIV    : sclk half-period in clk cycles (1..255)
//   DATA_WIDTH : sclk cycles per transfer (1..32)
//   CPOL       : sclk idle level
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   start      : transfer request, sampled only while idle
//   abort      : synchronous cancel of a running transfer
//   sclk       : serial clock (registered)
//   lead_edge  : strobe with each sclk transition away from CPOL
//   trail_edge : strobe with each sclk transition back to CPOL
//   busy       : high while a transfer is running
//   done       : one-cycle completion strobe
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        CPOL       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic busy,
  output logic done
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned EDGE_W = $clog2(2 * DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic [EDGE_W-1:0] edge_q,  edge_d;
  logic [EDGE_W-1:0] edge_inc;
  logic              sclk_q,  sclk_d;
  logic              lead_q,  lead_d;
  logic              trail_q, trail_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  assign edge_inc = edge_q + EDGE_W'(1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        sclk_d = CPOL;
        // start beats a simultaneous abort here: abort only matters in RUN
        if (start) begin
          state_d = S_RUN;
          div_d   = '0;
          edge_d  = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          sclk_d  = CPOL;
          div_d   = '0;
          edge_d  = '0;
        end else if (div_q == DIV_MAX) begin
          // Toggle is registered, so the strobe lines up with the new level.
          div_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_inc;
          // edge_q counts toggles already made: even -> this one is odd (lead)
          if (edge_q[0]) trail_d = 1'b1;
          else           lead_d  = 1'b1;
          if (edge_inc == EDGE_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        // Last trailing toggle already restored CPOL; start/abort ignored.
        state_d = S_IDLE;
        sclk_d  = CPOL;
        div_d   = '0;
        edge_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = CPOL;
        div_d   = '0;
        edge_d  = '0;
      end
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= CPOL;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk       = sclk_q;
  assign lead_edge  = lead_q;
  assign trail_edge = trail_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: two instances (defaults; CPOL=1/CLK_DIV=1/DATA_WIDTH=4)
// checked every cycle against a transfer-offset model, plus literal event
// timing checks for directed scenarios.
module tb_spi_sclk_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic sclk_a, lead_a, trail_a, busy_a, done_a;
  logic sclk_b, lead_b, trail_b, busy_b, done_b;

  always #5 clk = ~clk;

  spi_sclk_gen u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .sclk(sclk_a), .lead_edge(lead_a), .trail_edge(trail_a),
    .busy(busy_a), .done(done_a)
  );

  spi_sclk_gen #(.CLK_DIV(1), .DATA_WIDTH(4), .CPOL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .sclk(sclk_b), .lead_edge(lead_b), .trail_edge(trail_b),
    .busy(busy_b), .done(done_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  // A transfer is just an offset k from its first busy cycle: busy for
  // k < L, done at k == L, a toggle every CLK_DIV cycles.
  localparam int LA = 2 * 8 * 2;
  localparam int LB = 2 * 4 * 1;
  bit ma_act = 0, mb_act = 0;
  int ma_k = 0, mb_k = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ma_act <= 0;
    else if (!ma_act) begin
      if (start_a) begin ma_act <= 1; ma_k <= 0; end
    end else if (ma_k < LA && abort_a) ma_act <= 0;
    else if (ma_k >= LA) ma_act <= 0;
    else ma_k <= ma_k + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mb_act <= 0;
    else if (!mb_act) begin
      if (start_b) begin mb_act <= 1; mb_k <= 0; end
    end else if (mb_k < LB && abort_b) mb_act <= 0;
    else if (mb_k >= LB) mb_act <= 0;
    else mb_k <= mb_k + 1;
  end

  // {sclk, lead, trail, busy, done}
  function automatic logic [4:0] expv(int cd, int dw, logic cpol, bit act, int k);
    int j;
    logic tog;
    if (!act) return {cpol, 4'b0000};
    j   = k / cd;
    tog = (k > 0) && (k % cd == 0);
    return {cpol ^ (j % 2 == 1), tog && (j % 2 == 1), tog && (j % 2 == 0),
            k < 2 * dw * cd, k == 2 * dw * cd};
  endfunction

  // ---------------- per-cycle compare + event logs ----------------
  bit log_a = 0, log_b = 0;
  int t0_a = 0, t0_b = 0;
  int lead_qa[$], trail_qa[$], done_qa[$], brise_qa[$];
  int lead_qb[$], trail_qb[$], done_qb[$], brise_qb[$];
  logic lead_sclk_qb[$];
  int busy_cnt_a = 0;
  logic sclk34_a = 1'bx;
  logic bprev_a = 0, bprev_b = 0;

  always @(negedge clk) begin
    int ra, rb;
    chk("model_a", int'({sclk_a, lead_a, trail_a, busy_a, done_a}),
        int'(expv(2, 8, 1'b0, ma_act, ma_k)));
    chk("model_b", int'({sclk_b, lead_b, trail_b, busy_b, done_b}),
        int'(expv(1, 4, 1'b1, mb_act, mb_k)));
    ra = cyc - t0_a;
    rb = cyc - t0_b;
    if (log_a) begin
      if (lead_a)  lead_qa.push_back(ra);
      if (trail_a) trail_qa.push_back(ra);
      if (done_a)  done_qa.push_back(ra);
      if (busy_a && !bprev_a) brise_qa.push_back(ra);
      if (busy_a) busy_cnt_a++;
      if (ra == 34) sclk34_a = sclk_a;
    end
    if (log_b) begin
      if (lead_b) begin lead_qb.push_back(rb); lead_sclk_qb.push_back(sclk_b); end
      if (trail_b) trail_qb.push_back(rb);
      if (done_b)  done_qb.push_back(rb);
      if (busy_b && !bprev_b) brise_qb.push_back(rb);
    end
    bprev_a <= busy_a;
    bprev_b <= busy_b;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_a();
    lead_qa.delete(); trail_qa.delete(); done_qa.delete(); brise_qa.delete();
    busy_cnt_a = 0;
    t0_a = cyc;
  endtask

  task automatic clr_b();
    lead_qb.delete(); trail_qb.delete(); done_qb.delete(); brise_qb.delete();
    lead_sclk_qb.delete();
    t0_b = cyc;
  endtask

  initial begin
    // reset state
    tick(2);
    chk("reset_a", int'({sclk_a, lead_a, trail_a, busy_a, done_a}), 0);
    chk("reset_b", int'({sclk_b, lead_b, trail_b, busy_b, done_b}), 5'b10000);
    rst_n = 1'b1;

    // 1: defaults, single start in cycle 0 right after reset release
    clr_a(); log_a = 1; start_a = 1;
    tick(1); start_a = 0;
    tick(40); log_a = 0;
    chk("t1_first_busy", brise_qa.size() > 0 ? brise_qa[0] : -1, 1);
    chk("t1_busy_cycles", busy_cnt_a, 32);
    chk("t1_lead_count", lead_qa.size(), 8);
    for (int i = 0; i < lead_qa.size() && i < 8; i++) chk("t1_lead_at", lead_qa[i], 3 + 4 * i);
    chk("t1_trail_count", trail_qa.size(), 8);
    for (int i = 0; i < trail_qa.size() && i < 8; i++) chk("t1_trail_at", trail_qa[i], 5 + 4 * i);
    chk("t1_done_count", done_qa.size(), 1);
    chk("t1_done_at", done_qa.size() > 0 ? done_qa[0] : -1, 33);
    chk("t1_sclk_c34", int'(sclk34_a), 0);

    // 2: CPOL=1/CLK_DIV=1/DW=4, start with abort in IDLE; abort alone on idle A
    clr_b(); log_b = 1; start_b = 1; abort_b = 1; abort_a = 1;
    tick(1); start_b = 0; abort_b = 0; abort_a = 0;
    tick(14); log_b = 0;
    chk("t2_idle_a_after_abort", int'(busy_a), 0);
    chk("t2_first_busy", brise_qb.size() > 0 ? brise_qb[0] : -1, 1);
    chk("t2_lead_count", lead_qb.size(), 4);
    for (int i = 0; i < lead_qb.size() && i < 4; i++) begin
      chk("t2_lead_at", lead_qb[i], 2 + 2 * i);
      chk("t2_lead_sclk", int'(lead_sclk_qb[i]), 0);
    end
    chk("t2_trail_count", trail_qb.size(), 4);
    for (int i = 0; i < trail_qb.size() && i < 4; i++) chk("t2_trail_at", trail_qb[i], 3 + 2 * i);
    chk("t2_done_count", done_qb.size(), 1);
    chk("t2_done_at", done_qb.size() > 0 ? done_qb[0] : -1, 9);

    // 3: start held high 40 cycles -> two transfers, second busy in cycle 35
    clr_a(); log_a = 1; start_a = 1;
    tick(40); start_a = 0;
    tick(40); log_a = 0;
    chk("t3_transfers", done_qa.size(), 2);
    chk("t3_busy_rises", brise_qa.size(), 2);
    chk("t3_second_busy", brise_qa.size() > 1 ? brise_qa[1] : -1, 35);
    chk("t3_done0", done_qa.size() > 0 ? done_qa[0] : -1, 33);
    chk("t3_done1", done_qa.size() > 1 ? done_qa[1] : -1, 67);

    // 4: abort in cycle 10, restart in cycle 12
    clr_a(); log_a = 1; start_a = 1;
    tick(1); start_a = 0;
    tick(9); abort_a = 1;
    tick(1); abort_a = 0;
    chk("t4_after_abort", int'({sclk_a, lead_a, trail_a, busy_a, done_a}), 0);
    tick(1); start_a = 1;
    tick(1); start_a = 0;
    tick(40); log_a = 0;
    chk("t4_done_count", done_qa.size(), 1);
    chk("t4_done_at", done_qa.size() > 0 ? done_qa[0] : -1, 45);
    chk("t4_restart_busy", brise_qa.size() > 1 ? brise_qa[1] : -1, 13);
    chk("t4_lead_total", lead_qa.size(), 10);

    // 5: asynchronous reset mid-cycle 15
    clr_a(); start_a = 1; start_b = 1;
    tick(1); start_a = 0; start_b = 0;
    tick(14);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_a", int'({sclk_a, lead_a, trail_a, busy_a, done_a}), 0);
    chk("t5_async_b", int'({sclk_b, lead_b, trail_b, busy_b, done_b}), 5'b10000);
    tick(1); rst_n = 1'b1;
    clr_a(); log_a = 1;
    tick(5);
    chk("t5_no_done_after", done_qa.size(), 0);
    clr_a(); start_a = 1;
    tick(1); start_a = 0;
    tick(36); log_a = 0;
    chk("t5_edges", lead_qa.size() + trail_qa.size(), 16);
    chk("t5_done_at", done_qa.size() > 0 ? done_qa[0] : -1, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, SCLK cycles per transfer; legal range 1..32.
REQ-003 SHALL have parameter CPOL, default 0, SCLK idle level.
REQ-004 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port start  input  1  transfer request, level-sampled each cycle.
REQ-007 SHALL have port abort  input  1  synchronous cancel of a running transfer.
REQ-008 SHALL have port sclk  output  1  generated SPI serial clock, registered.
REQ-009 SHALL have port lead_edge  output  1  one-cycle strobe, coincident with each sclk transition away from CPOL.
REQ-010 SHALL have port trail_edge  output  1  one-cycle strobe, coincident with each sclk transition back to CPOL.
REQ-011 SHALL have port busy  output  1  high while state is RUN.
REQ-012 SHALL have port done  output  1  one-cycle completion strobe.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; all outputs registered.
REQ-014 IDLE: sclk=CPOL; busy, done, lead_edge and trail_edge all 0.
REQ-015 IDLE->RUN when start=1 is sampled; div_cnt and edge_cnt cleared; busy=1 from the next cycle.
REQ-016 start in RUN or DONE SHALL be ignored; no queuing.
REQ-017 RUN: div_cnt SHALL increment each cycle and wrap to 0 at CLK_DIV-1.
REQ-018 RUN: on the wrap, sclk toggles, edge_cnt increments, and the matching strobe is 1 in the same cycle the new sclk level is visible.
REQ-019 Odd-numbered toggles (1st, 3rd, ...) SHALL be lead_edge; even-numbered toggles SHALL be trail_edge.
REQ-020 lead_edge and trail_edge SHALL never be 1 in the same cycle.
REQ-021 The first toggle SHALL be visible CLK_DIV cycles after busy rises.
REQ-022 On the 2*DATA_WIDTH-th toggle, the state SHALL go RUN->DONE.
REQ-023 DONE lasts exactly 1 cycle: done=1, trail_edge=1, sclk=CPOL, busy=0; the next state is IDLE.
REQ-024 abort=1 in RUN SHALL force IDLE on the next edge: sclk=CPOL, strobes 0, busy=0, done never asserted.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 abort and start asserted together in IDLE: start wins and the transfer begins.
REQ-027 Width: div_cnt SHALL be $clog2(CLK_DIV+1) bits; edge_cnt SHALL be $clog2(2*DATA_WIDTH+1) bits; no overflow is possible within legal ranges.
REQ-028 CLK_DIV=1 SHALL toggle sclk every cycle while in RUN (sclk = clk/2).
REQ-029 Transfer length SHALL be exactly 2*DATA_WIDTH*CLK_DIV cycles, measured from the first busy cycle to the done cycle inclusive-exclusive.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, sclk=CPOL, busy=0, done=0, lead_edge=0, trail_edge=0, and div_cnt=edge_cnt=0.
REQ-031 Reset asserted mid-transfer SHALL discard the transfer; no done is produced after release.
REQ-032 After rst_n rises, the first start SHALL be honoured on the first clk edge.

Verification
REQ-033 Defaults (CLK_DIV=2, DATA_WIDTH=8, CPOL=0), start pulsed in cycle 0 -> busy=1 in cycles 1..32; lead_edge in cycles 3,7,...,31; trail_edge in cycles 5,9,...,33; done=1 and busy=0 only in cycle 33; sclk=0 in cycle 34.
REQ-034 CPOL=1, CLK_DIV=1, DATA_WIDTH=4, single start -> sclk idles at 1; 8 toggles on consecutive cycles; 4 lead_edge strobes, each with sclk=0; done coincides with the 4th trail_edge.
REQ-035 Defaults, start held high for 40 cycles -> exactly 2 transfers; the second busy rises in cycle 35 (start sampled in IDLE cycle 34); start during RUN/DONE is ignored.
REQ-036 Defaults, abort pulsed in cycle 10 -> sclk=0, busy=0 and no strobes from cycle 11; done never asserts; a start in cycle 12 begins a clean full transfer.
REQ-037 Defaults, rst_n driven low mid-cycle in cycle 15 -> all outputs at reset values before the next clk edge; no done after release; the next start yields a full 16-edge transfer.
